// File: rtl/uart_tx_pkg.sv
// Shared definitions for the external-interface UART transmitter:
// register indices, STATUS/CTRL bit positions, FSM encodings and a
// debug snapshot struct. Optional parity support is selected with the
// UART_TX_PARITY_EN macro in the files that import this package.
package uart_tx_pkg;

  // Register word indices (low two address bits once the upper bits are zero)
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  // STATUS bit positions
  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_LVL_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_IRQ_EMPTY = 1;
  localparam int CTRL_IRQ_OVF   = 2;
  localparam int CTRL_PAR_ODD   = 3;

  typedef enum logic [1:0] {IDLE, ACK, WAIT} bus_state_t;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} tx_state_t;

  // Snapshot of both state machines for checkers to bind to
  typedef struct packed {
    bus_state_t bus;
    tx_state_t  tx;
    logic [2:0] bit_idx;
  } uart_tx_dbg_t;

  // A divider of zero would never end a bit; treat it as one cycle per bit
  function automatic logic [15:0] eff_div(input logic [15:0] baud);
    return (baud == 16'd0) ? 16'd1 : baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. DEPTH must be a power
// of two so the read/write pointers wrap naturally. Full/empty are judged
// on the registered state, so a push into a full FIFO is dropped even if
// a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ext_if_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the responder side of an
// external-interface bus bridge: register file, TX FIFO, baud divider
// and frame shifter. Defining UART_TX_PARITY_EN inserts a parity bit
// (even, or odd when CTRL[3]=1) between the data and stop bits.
module ext_if_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 434,
  parameter int ADDR_W      = 3
) (
  input  logic              clk_clk,
  input  logic              rst_reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              bus_enable,
  input  logic [3:0]        byte_enable,
  input  logic              rw,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              acknowledge,
  output logic              irq,
  output logic              uart_txd
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  // Handshake: the bridge raises bus_enable with address/rw/data stable and
  // holds it until it sees acknowledge. The access takes effect on the edge
  // that leaves IDLE; acknowledge (and read_data) are valid for exactly the
  // following cycle. The FSM then waits for bus_enable to drop so a held
  // request is never executed twice.
  bus_state_t bus_q, bus_d;

  tx_state_t  tx_q, tx_d;
  logic [15:0] cnt_q;
  logic [15:0] div_q;
  logic [2:0]  bit_q;
  logic [7:0]  sh_q;

  logic [3:0]  ctrl_q;
  logic [15:0] baud_q;
  logic        ovf_q;
  logic        irq_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;

  logic        access;
  logic        wr_acc;
  logic        rd_acc;
  logic        is_low;
  logic [1:0]  sel;
  logic        push_req;
  logic        status_wr;
  logic        ctrl_wr;
  logic        baud_wr;

  logic        fifo_pop;
  logic [7:0]  fifo_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [8:0]  level9;
  logic [7:0]  level8;

  logic        busy;
  logic        load;
  logic        bit_end;
  logic        txd;

  uart_tx_dbg_t dbg_state;

  assign is_low    = ((address >> 2) == '0);
  assign sel       = address[1:0];
  assign access    = (bus_q == IDLE) && bus_enable;
  assign wr_acc    = access && !rw;
  assign rd_acc    = access && rw;
  assign push_req  = wr_acc && is_low && (sel == REG_DATA) && byte_enable[0];
  assign status_wr = wr_acc && is_low && (sel == REG_STATUS);
  assign ctrl_wr   = wr_acc && is_low && (sel == REG_CTRL);
  assign baud_wr   = wr_acc && is_low && (sel == REG_BAUD);

  assign acknowledge = (bus_q == ACK);
  assign read_data   = rdata_q;
  assign irq         = irq_q;
  assign uart_txd    = txd;
  assign busy        = (tx_q != S_IDLE);

  // A 256-deep FIFO can hold 256 bytes; the 8-bit level field saturates at 255
  assign level9 = 9'(fifo_level);
  assign level8 = level9[8] ? 8'hFF : level9[7:0];

  assign dbg_state = '{bus: bus_q, tx: tx_q, bit_idx: bit_q};

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .LVL_W(LVL_W)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (rst_reset_n),
    .push      (push_req),
    .push_data (write_data[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Bus FSM state register
  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) bus_q <= IDLE;
    else              bus_q <= bus_d;
  end

  // Bus FSM next state
  always_comb begin
    bus_d = bus_q;
    case (bus_q)
      IDLE:    if (bus_enable) bus_d = ACK;
      ACK:     bus_d = bus_enable ? WAIT : IDLE;
      WAIT:    if (!bus_enable) bus_d = IDLE;
      default: bus_d = IDLE;
    endcase
  end

  // Register read multiplexer; unmapped indices read as zero
  always_comb begin
    rd_mux = 32'h0;
    if (is_low) begin
      case (sel)
        REG_STATUS: begin
          rd_mux[ST_BUSY]               = busy;
          rd_mux[ST_FULL]               = fifo_full;
          rd_mux[ST_EMPTY]              = fifo_empty;
          rd_mux[ST_OVF]                = ovf_q;
          rd_mux[ST_LVL_LSB+7:ST_LVL_LSB] = level8;
        end
        REG_CTRL: rd_mux[3:0]  = ctrl_q;
        REG_BAUD: rd_mux[15:0] = baud_q;
        default:  rd_mux = 32'h0;
      endcase
    end
  end

  // Register file, overflow flag, read data capture and registered irq
  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      ctrl_q  <= 4'h1;
      baud_q  <= 16'(DEFAULT_DIV);
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      if (rd_acc) rdata_q <= rd_mux;
      if (ctrl_wr && byte_enable[0]) begin
`ifdef UART_TX_PARITY_EN
        ctrl_q <= write_data[3:0];
`else
        ctrl_q <= {1'b0, write_data[2:0]};
`endif
      end
      if (baud_wr && byte_enable[0]) baud_q[7:0]  <= write_data[7:0];
      if (baud_wr && byte_enable[1]) baud_q[15:8] <= write_data[15:8];
      if (push_req && fifo_full) begin
        ovf_q <= 1'b1;
      end else if (status_wr && byte_enable[0] && write_data[ST_OVF]) begin
        ovf_q <= 1'b0;
      end
      irq_q <= (ctrl_q[CTRL_IRQ_EMPTY] && fifo_empty && !busy) ||
               (ctrl_q[CTRL_IRQ_OVF] && ovf_q);
    end
  end

  assign bit_end = (cnt_q == div_q - 16'd1);

  // Shifter FSM state register
  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) tx_q <= S_IDLE;
    else              tx_q <= tx_d;
  end

  // Shifter FSM next state and FIFO load strobe
  always_comb begin
    tx_d     = tx_q;
    load     = 1'b0;
    fifo_pop = 1'b0;
    case (tx_q)
      S_IDLE: begin
        if (ctrl_q[CTRL_TX_EN] && !fifo_empty) begin
          load     = 1'b1;
          fifo_pop = 1'b1;
          tx_d     = S_START;
        end
      end
      S_START: if (bit_end) tx_d = S_DATA;
      S_DATA: begin
        if (bit_end && (bit_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          tx_d = S_PAR;
`else
          tx_d = S_STOP;
`endif
        end
      end
      S_PAR:   if (bit_end) tx_d = S_STOP;
      S_STOP:  if (bit_end) tx_d = S_IDLE;
      default: tx_d = S_IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  logic par_q;

  // Parity is fixed at frame start together with the data and divider
  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n)  par_q <= 1'b0;
    else if (load)     par_q <= (^fifo_data) ^ ctrl_q[CTRL_PAR_ODD];
  end
`endif

  // Bit timer, bit index and data shift register
  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      cnt_q <= 16'd0;
      div_q <= 16'd1;
      bit_q <= 3'd0;
      sh_q  <= 8'h00;
    end else if (load) begin
      cnt_q <= 16'd0;
      div_q <= eff_div(baud_q);
      bit_q <= 3'd0;
      sh_q  <= fifo_data;
    end else if (tx_q != S_IDLE) begin
      if (bit_end) begin
        cnt_q <= 16'd0;
        if (tx_q == S_DATA) begin
          sh_q  <= {1'b0, sh_q[7:1]};
          bit_q <= bit_q + 3'd1;
        end
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Line driver decoded from shifter state; idles high out of reset
  always_comb begin
    txd = 1'b1;
    case (tx_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = sh_q[0];
`ifdef UART_TX_PARITY_EN
      S_PAR:   txd = par_q;
`else
      S_PAR:   txd = 1'b1;
`endif
      default: txd = 1'b1;
    endcase
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, write_data[31:16], byte_enable[3:2], dbg_state};

endmodule

// File: tb/tb_ext_if_uart_tx.sv
// Directed bench for ext_if_uart_tx: register table, frame timing,
// overflow/irq, held bus request, mid-frame baud change, reset abort and
// (with UART_TX_PARITY_EN) parity polarity.
module tb_ext_if_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS = 10 + PAR;

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_CTRL   = 3'd2;
  localparam logic [2:0] A_BAUD   = 3'd3;

  logic        clk_clk = 1'b0;
  logic        rst_reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        bus_enable = 1'b0;
  logic [3:0]  byte_enable = '0;
  logic        rw = 1'b1;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        acknowledge;
  logic        irq;
  logic        uart_txd;

  int n_chk = 0;
  int n_pass = 0;

  logic       cap_en = 1'b0;
  logic       cap_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [2:0]  addr;
    logic        rw;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];

  ext_if_uart_tx #(
    .FIFO_DEPTH(16),
    .DEFAULT_DIV(434),
    .ADDR_W(3)
  ) dut (
    .clk_clk     (clk_clk),
    .rst_reset_n (rst_reset_n),
    .address     (address),
    .bus_enable  (bus_enable),
    .byte_enable (byte_enable),
    .rw          (rw),
    .write_data  (write_data),
    .read_data   (read_data),
    .acknowledge (acknowledge),
    .irq         (irq),
    .uart_txd    (uart_txd)
  );

  // Clock
  always #5 clk_clk = ~clk_clk;

  // Line capture, one sample per cycle away from the active edge
  always @(negedge clk_clk) if (cap_en) cap_q.push_back(uart_txd);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_reset_n = 1'b0;
    bus_enable  = 1'b0;
    rw          = 1'b1;
    address     = '0;
    byte_enable = '0;
    write_data  = '0;
    repeat (3) @(negedge clk_clk);
    rst_reset_n = 1'b1;
    @(negedge clk_clk);
  endtask

  // One bus transfer; entered and left at a falling clock edge
  task automatic bus_xfer(input logic [2:0] a, input logic r, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd);
    int lat;
    lat = 0;
    address = a; rw = r; byte_enable = be; write_data = wd; bus_enable = 1'b1;
    do begin
      @(negedge clk_clk);
      lat++;
    end while (acknowledge !== 1'b1 && lat < 8);
    chk("ack_latency", lat, 1);
    rd = read_data;
    bus_enable = 1'b0;
    @(negedge clk_clk);
    chk("ack_single_pulse", {31'b0, acknowledge}, 32'h0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_xfer(a, 1'b0, be, wd, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus_xfer(a, 1'b1, 4'hF, 32'h0, rd);
    chk(name, rd, exp);
  endtask

  task automatic add(input logic [2:0] a, input logic r, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] exp, input string name);
    vec_t v;
    v.addr = a; v.rw = r; v.be = be; v.wd = wd; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  function automatic int find_start(input int from);
    for (int i = from; i < cap_q.size(); i++) if (cap_q[i] == 1'b0) return i;
    return -1;
  endfunction

  // Compare one captured frame against the next expected byte
  task automatic check_frame(input int s, input int bc, input logic odd, output int nxt);
    logic [7:0]      d;
    logic [NBITS-1:0] bits;
    int good;
    int idx;
    d = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    nxt = 0;
    if (s < 0) begin
      chk($sformatf("frame_%02h_start_found", d), 0, 1);
      return;
    end
    bits = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (PAR == 1) bits[9] = (^d) ^ odd;
    bits[NBITS-1] = 1'b1;
    for (int b = 0; b < NBITS; b++) begin
      good = 0;
      for (int c = 0; c < bc; c++) begin
        idx = s + b * bc + c;
        if (idx < cap_q.size() && cap_q[idx] === bits[b]) good++;
      end
      chk($sformatf("frame_%02h_bit%0d_cycles", d, b), good, bc);
    end
    nxt = s + NBITS * bc;
  endtask

  initial begin
    int s;
    int nxt;
    int acks;
    int ones;
    logic [31:0] ctrl_all;
    ctrl_all = (PAR == 1) ? 32'hF : 32'h7;

    // Reset values and register table
    do_reset();
    chk("rst_txd", {31'b0, uart_txd}, 32'h1);
    chk("rst_ack", {31'b0, acknowledge}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_read_data", read_data, 32'h0);

    add(A_STATUS, 1, 4'hF, 0,            32'h0000_0004, "status_reset");
    add(A_BAUD,   1, 4'hF, 0,            32'd434,       "baud_reset");
    add(A_CTRL,   1, 4'hF, 0,            32'h1,         "ctrl_reset");
    add(A_DATA,   1, 4'hF, 0,            32'h0,         "data_reads_zero");
    add(A_CTRL,   0, 4'h1, 32'hFFFF_FFFF, 0,            "");
    add(A_CTRL,   1, 4'hF, 0,            ctrl_all,      "ctrl_all_bits");
    add(A_CTRL,   0, 4'hE, 32'h0,        0,             "");
    add(A_CTRL,   1, 4'hF, 0,            ctrl_all,      "ctrl_lane_masked");
    add(A_BAUD,   0, 4'h1, 32'h0000_1234, 0,            "");
    add(A_BAUD,   1, 4'hF, 0,            32'h0000_0134, "baud_lane0");
    add(A_BAUD,   0, 4'h2, 32'hABCD_5678, 0,            "");
    add(A_BAUD,   1, 4'hF, 0,            32'h0000_5634, "baud_lane1");
    add(A_BAUD,   0, 4'hF, 32'hFFFF_0010, 0,            "");
    add(A_BAUD,   1, 4'hF, 0,            32'h0000_0010, "baud_both_lanes");
    add(3'd5,     0, 4'hF, 32'hFFFF_FFFF, 0,            "");
    add(3'd5,     1, 4'hF, 0,            32'h0,         "unmapped5_zero");
    add(3'd7,     1, 4'hF, 0,            32'h0,         "unmapped7_zero");
    add(A_CTRL,   0, 4'h1, 32'h1,        0,             "");
    add(A_CTRL,   1, 4'hF, 0,            32'h1,         "ctrl_restored");
    for (int i = 0; i < tbl.size(); i++) begin
      logic [31:0] rd;
      bus_xfer(tbl[i].addr, tbl[i].rw, tbl[i].be, tbl[i].wd, rd);
      if (tbl[i].rw) chk(tbl[i].name, rd, tbl[i].exp);
    end

    // 0xA5 at 4 cycles per bit
    do_reset();
    wr(A_BAUD, 4'h3, 32'd4);
    cap_q.delete();
    cap_en = 1'b1;
    exp_q.push_back(8'hA5);
    wr(A_DATA, 4'h1, 32'hA5);
    rd_chk("status_busy_mid_frame", A_STATUS, 32'h0000_0005);
    repeat (55) @(negedge clk_clk);
    cap_en = 1'b0;
    check_frame(find_start(0), 4, 1'b0, nxt);
    ones = 0;
    for (int i = nxt; i < cap_q.size(); i++) if (cap_q[i] === 1'b1) ones++;
    chk("idle_high_after_frame", ones, cap_q.size() - nxt);
    rd_chk("status_after_frame", A_STATUS, 32'h0000_0004);

    // BAUD=0 behaves as one cycle per bit
    wr(A_BAUD, 4'h3, 32'd0);
    cap_q.delete();
    cap_en = 1'b1;
    exp_q.push_back(8'h5A);
    wr(A_DATA, 4'h1, 32'h5A);
    repeat (20) @(negedge clk_clk);
    cap_en = 1'b0;
    check_frame(find_start(0), 1, 1'b0, nxt);

    // Overflow, irq and drain
    do_reset();
    wr(A_CTRL, 4'h1, 32'h4);
    for (int i = 0; i < 17; i++) wr(A_DATA, 4'h1, 32'(i));
    rd_chk("status_full_ovf", A_STATUS, 32'h0000_100A);
    chk("irq_ovf", {31'b0, irq}, 32'h1);
    wr(A_STATUS, 4'h1, 32'h8);
    rd_chk("status_ovf_cleared", A_STATUS, 32'h0000_1002);
    chk("irq_ovf_cleared", {31'b0, irq}, 32'h0);
    wr(A_BAUD, 4'h3, 32'd1);
    wr(A_CTRL, 4'h1, 32'h7);
    chk("irq_low_while_draining", {31'b0, irq}, 32'h0);
    repeat (16 * (NBITS + 1) + 20) @(negedge clk_clk);
    rd_chk("status_drained", A_STATUS, 32'h0000_0004);
    chk("irq_empty", {31'b0, irq}, 32'h1);

    // Request held for five cycles gives one acknowledge and one push
    do_reset();
    wr(A_CTRL, 4'h1, 32'h0);
    address = A_DATA; rw = 1'b0; byte_enable = 4'h1; write_data = 32'h3C;
    bus_enable = 1'b1;
    acks = 0;
    repeat (5) begin
      @(negedge clk_clk);
      if (acknowledge === 1'b1) acks++;
    end
    bus_enable = 1'b0;
    repeat (2) begin
      @(negedge clk_clk);
      if (acknowledge === 1'b1) acks++;
    end
    chk("held_ack_count", acks, 1);
    rd_chk("held_single_push", A_STATUS, 32'h0000_0100);

    // BAUD change mid-frame affects only the next frame
    do_reset();
    wr(A_BAUD, 4'h3, 32'd2);
    cap_q.delete();
    cap_en = 1'b1;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h81);
    wr(A_DATA, 4'h1, 32'h3C);
    wr(A_DATA, 4'h1, 32'h81);
    wr(A_BAUD, 4'h3, 32'd8);
    repeat (140) @(negedge clk_clk);
    cap_en = 1'b0;
    check_frame(find_start(0), 2, 1'b0, nxt);
    check_frame(find_start(nxt), 8, 1'b0, nxt);

    // Reset mid-frame returns the line high at once and empties the FIFO
    do_reset();
    wr(A_BAUD, 4'h3, 32'd4);
    wr(A_DATA, 4'h1, 32'h00);
    wr(A_DATA, 4'h1, 32'h00);
    repeat (8) @(negedge clk_clk);
    chk("txd_low_mid_frame", {31'b0, uart_txd}, 32'h0);
    #2 rst_reset_n = 1'b0;
    #1 chk("txd_high_on_reset", {31'b0, uart_txd}, 32'h1);
    @(negedge clk_clk);
    repeat (2) @(negedge clk_clk);
    rst_reset_n = 1'b1;
    @(negedge clk_clk);
    rd_chk("status_after_abort", A_STATUS, 32'h0000_0004);
    chk("txd_idle_after_abort", {31'b0, uart_txd}, 32'h1);

`ifdef UART_TX_PARITY_EN
    // Parity polarity on 0x07
    do_reset();
    wr(A_BAUD, 4'h3, 32'd2);
    cap_q.delete();
    cap_en = 1'b1;
    exp_q.push_back(8'h07);
    wr(A_DATA, 4'h1, 32'h07);
    repeat (30) @(negedge clk_clk);
    cap_en = 1'b0;
    s = find_start(0);
    check_frame(s, 2, 1'b0, nxt);
    chk("parity_even_07", (s >= 0 && s + 19 < cap_q.size()) ? {31'b0, cap_q[s+18]} : 32'hX, 32'h1);
    wr(A_CTRL, 4'h1, 32'h9);
    rd_chk("ctrl_parity_odd", A_CTRL, 32'h9);
    cap_q.delete();
    cap_en = 1'b1;
    exp_q.push_back(8'h07);
    wr(A_DATA, 4'h1, 32'h07);
    repeat (30) @(negedge clk_clk);
    cap_en = 1'b0;
    s = find_start(0);
    check_frame(s, 2, 1'b1, nxt);
    chk("parity_odd_07", (s >= 0 && s + 19 < cap_q.size()) ? {31'b0, cap_q[s+18]} : 32'hX, 32'h0);
`else
    s = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
